branch_perf_counters: RTL and testbench

Parametrised branch-prediction statistics unit for the pipelined core. It counts resolved branches and mispredictions globally and per branch channel, and tracks the current and longest runs of consecutive mispredictions. It also latches a periodic windowed snapshot for software or testbench sampling. It sits beside the branch-resolution stage, which drives one update per resolved branch.

---
 rtl/branch_perf_counters.sv | 138 +++++++++++++
 tb/tb_branch_perf_counters.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_perf_counters.sv
// rtl/branch_perf_counters.sv - branch-prediction statistics: global/per-channel counts, mispredict runs, windowed snapshots
// Optional feature macro: BRANCH_PERF_SATURATE_EN (defined: counters saturate at all-ones; undefined: counters wrap)
module branch_perf_counters #(
    parameter int CNT_W  = 32,
    parameter int N_CH   = 4,
    parameter int CH_W   = 2,
    parameter int WINDOW = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update_en,
    input  logic [CH_W-1:0]  update_ch,
    input  logic             control_hazard,
    input  logic             clear,
    input  logic             freeze,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [CNT_W-1:0] branch_predict_total,
    output logic [CNT_W-1:0] branch_false,
    output logic [CNT_W-1:0] ch_total,
    output logic [CNT_W-1:0] ch_false,
    output logic [CNT_W-1:0] miss_run,
    output logic [CNT_W-1:0] miss_run_max,
    output logic [CNT_W-1:0] snap_total,
    output logic [CNT_W-1:0] snap_false,
    output logic             window_done
);

    localparam int              WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    // Increment that either saturates or wraps depending on the build
    function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
`ifdef BRANCH_PERF_SATURATE_EN
        f_inc = (&v) ? v : v + CNT_W'(1);
`else
        f_inc = v + CNT_W'(1);
`endif
    endfunction

    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_false;
    logic [CNT_W-1:0] r_miss_run;
    logic [CNT_W-1:0] r_miss_run_max;
    logic [CNT_W-1:0] r_ch_total [N_CH];
    logic [CNT_W-1:0] r_ch_false [N_CH];
    logic [CNT_W-1:0] r_snap_total;
    logic [CNT_W-1:0] r_snap_false;
    logic [WIN_W-1:0] r_win_cnt;
    logic             r_window_done;

    logic [CNT_W-1:0] w_total_nxt;
    logic [CNT_W-1:0] w_false_nxt;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_max_nxt;
    logic             w_miss;

    assign w_miss      = update_en & control_hazard;
    assign w_total_nxt = update_en ? f_inc(r_total) : r_total;
    assign w_false_nxt = w_miss ? f_inc(r_false) : r_false;
    // Idle cycles leave the run untouched; only a correct prediction breaks it
    assign w_run_nxt   = !update_en ? r_miss_run :
                         (control_hazard ? f_inc(r_miss_run) : '0);
    assign w_max_nxt   = (w_run_nxt > r_miss_run_max) ? w_run_nxt : r_miss_run_max;

    // Global counters and run registers: rst > clear > freeze > update
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_total        <= '0;
            r_false        <= '0;
            r_miss_run     <= '0;
            r_miss_run_max <= '0;
        end else if (!freeze) begin
            r_total        <= w_total_nxt;
            r_false        <= w_false_nxt;
            r_miss_run     <= w_run_nxt;
            r_miss_run_max <= w_max_nxt;
        end
    end

    // Per-channel counters; out-of-range channels match no slot and are dropped here
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst || clear) begin
                r_ch_total[i] <= '0;
                r_ch_false[i] <= '0;
            end else if (!freeze && update_en && (update_ch == CH_W'(i))) begin
                r_ch_total[i] <= f_inc(r_ch_total[i]);
                if (control_hazard) begin
                    r_ch_false[i] <= f_inc(r_ch_false[i]);
                end
            end
        end
    end

    // Window counter and snapshot capture; snapshots include the last cycle's event and survive clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt     <= '0;
            r_snap_total  <= '0;
            r_snap_false  <= '0;
            r_window_done <= 1'b0;
        end else if (clear) begin
            r_win_cnt     <= '0;
            r_window_done <= 1'b0;
        end else if (freeze) begin
            r_window_done <= 1'b0;
        end else if (r_win_cnt == WIN_LAST) begin
            r_win_cnt     <= '0;
            r_snap_total  <= w_total_nxt;
            r_snap_false  <= w_false_nxt;
            r_window_done <= 1'b1;
        end else begin
            r_win_cnt     <= r_win_cnt + WIN_W'(1);
            r_window_done <= 1'b0;
        end
    end

    // Zero-latency per-channel read mux; unmatched selects read as 0
    always_comb begin
        ch_total = '0;
        ch_false = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                ch_total = r_ch_total[i];
                ch_false = r_ch_false[i];
            end
        end
    end

    assign branch_predict_total = r_total;
    assign branch_false         = r_false;
    assign miss_run             = r_miss_run;
    assign miss_run_max         = r_miss_run_max;
    assign snap_total           = r_snap_total;
    assign snap_false           = r_snap_false;
    assign window_done          = r_window_done;

endmodule

// File: tb/tb_branch_perf_counters.sv
// tb/tb_branch_perf_counters.sv - self-checking bench for branch_perf_counters
module tb_branch_perf_counters;

    localparam int CNT_W  = 4;
    localparam int N_CH   = 4;
    localparam int CH_W   = 3;
    localparam int WINDOW = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             update_en;
    logic [CH_W-1:0]  update_ch;
    logic             control_hazard;
    logic             clear;
    logic             freeze;
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] branch_predict_total;
    logic [CNT_W-1:0] branch_false;
    logic [CNT_W-1:0] ch_total;
    logic [CNT_W-1:0] ch_false;
    logic [CNT_W-1:0] miss_run;
    logic [CNT_W-1:0] miss_run_max;
    logic [CNT_W-1:0] snap_total;
    logic [CNT_W-1:0] snap_false;
    logic             window_done;

    always #5 clk = ~clk;

    branch_perf_counters #(.CNT_W(CNT_W), .N_CH(N_CH), .CH_W(CH_W), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .update_en(update_en), .update_ch(update_ch),
        .control_hazard(control_hazard), .clear(clear), .freeze(freeze), .rd_ch(rd_ch),
        .branch_predict_total(branch_predict_total), .branch_false(branch_false),
        .ch_total(ch_total), .ch_false(ch_false), .miss_run(miss_run),
        .miss_run_max(miss_run_max), .snap_total(snap_total), .snap_false(snap_false),
        .window_done(window_done)
    );

    int total_n = 0;
    int bad_n   = 0;

    // Reference model: true event counts as plain integers, mapped to the counter width on compare
    int m_tot, m_fal, m_run, m_mm, m_cyc, m_snap_t, m_snap_f, m_done;
    int m_cht[N_CH];
    int m_chf[N_CH];

    function automatic int fmt(input int x);
`ifdef BRANCH_PERF_SATURATE_EN
        return (x > CMAX) ? CMAX : x;
`else
        return x % (CMAX + 1);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        m_tot = 0; m_fal = 0; m_run = 0; m_mm = 0; m_cyc = 0;
        m_snap_t = 0; m_snap_f = 0; m_done = 0;
        for (int i = 0; i < N_CH; i++) begin m_cht[i] = 0; m_chf[i] = 0; end
    endtask

    task automatic mdl_step(input bit en, input int ch, input bit hz, input bit clr, input bit frz);
        if (clr) begin
            m_tot = 0; m_fal = 0; m_run = 0; m_mm = 0; m_cyc = 0; m_done = 0;
            for (int i = 0; i < N_CH; i++) begin m_cht[i] = 0; m_chf[i] = 0; end
        end else if (frz) begin
            m_done = 0;
        end else begin
            if (en) begin
                m_tot++;
                if (ch < N_CH) m_cht[ch]++;
                if (hz) begin
                    m_fal++;
                    if (ch < N_CH) m_chf[ch]++;
                    m_run++;
                end else begin
                    m_run = 0;
                end
                if (fmt(m_run) > m_mm) m_mm = fmt(m_run);
            end
            m_cyc++;
            if (m_cyc % WINDOW == 0) begin
                m_snap_t = fmt(m_tot);
                m_snap_f = fmt(m_fal);
                m_done   = 1;
            end else begin
                m_done = 0;
            end
        end
    endtask

    task automatic check_all();
        int r;
        r = int'(rd_ch);
        chk("total", 32'(branch_predict_total), fmt(m_tot));
        chk("false", 32'(branch_false), fmt(m_fal));
        chk("ch_total", 32'(ch_total), (r < N_CH) ? fmt(m_cht[r]) : 0);
        chk("ch_false", 32'(ch_false), (r < N_CH) ? fmt(m_chf[r]) : 0);
        chk("miss_run", 32'(miss_run), fmt(m_run));
        chk("miss_run_max", 32'(miss_run_max), m_mm);
        chk("snap_total", 32'(snap_total), m_snap_t);
        chk("snap_false", 32'(snap_false), m_snap_f);
        chk("window_done", 32'(window_done), m_done);
    endtask

    task automatic cyc(input bit en, input int ch, input bit hz, input bit clr, input bit frz);
        update_en      = en;
        update_ch      = CH_W'(ch);
        control_hazard = hz;
        clear          = clr;
        freeze         = frz;
        @(posedge clk);
        mdl_step(en, ch, hz, clr, frz);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; update_en = 0; update_ch = '0; control_hazard = 0;
        clear = 0; freeze = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_reset();
        check_all();
        chk("rst_total", 32'(branch_predict_total), 0);
        chk("rst_done", 32'(window_done), 0);
    endtask

    typedef struct {
        bit hz;
        int e_tot;
        int e_fal;
        int e_run;
        int e_max;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int k;
        int edges;
        bit hzpat[10] = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 0};
        int efal[10]  = '{1, 2, 2, 3, 4, 5, 5, 5, 6, 6};
        int erun[10]  = '{1, 2, 0, 1, 2, 3, 0, 0, 1, 0};
        int emax[10]  = '{1, 2, 2, 2, 2, 3, 3, 3, 3, 3};
        for (int i = 0; i < 10; i++) begin
            tbl[i].hz = hzpat[i]; tbl[i].e_tot = i + 1; tbl[i].e_fal = efal[i];
            tbl[i].e_run = erun[i]; tbl[i].e_max = emax[i];
        end

        rd_ch = 3'd1;
        do_reset();

        // Ten updates on channel 1 with a known hazard pattern
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, tbl[i].hz, 0, 0);
            chk("tbl_total", 32'(branch_predict_total), tbl[i].e_tot);
            chk("tbl_false", 32'(branch_false), tbl[i].e_fal);
            chk("tbl_ch1_total", 32'(ch_total), tbl[i].e_tot);
            chk("tbl_ch1_false", 32'(ch_false), tbl[i].e_fal);
            chk("tbl_run", 32'(miss_run), tbl[i].e_run);
            chk("tbl_max", 32'(miss_run_max), tbl[i].e_max);
        end

        // Out-of-range channel: global only
        cyc(1, 5, 1, 0, 0);
        chk("oor_false", 32'(branch_false), 7);
        chk("oor_total", 32'(branch_predict_total), 11);
        for (int r = 0; r < N_CH; r++) begin
            rd_ch = CH_W'(r);
            #1;
            chk("oor_ch_total", 32'(ch_total), (r == 1) ? 10 : 0);
            chk("oor_ch_false", 32'(ch_false), (r == 1) ? 6 : 0);
        end
        rd_ch = 3'd5;
        #1;
        chk("oor_rd_total", 32'(ch_total), 0);

        // Single update then zero-latency channel sweep
        do_reset();
        cyc(1, 2, 1, 0, 0);
        for (int r = 0; r < N_CH; r++) begin
            rd_ch = CH_W'(r);
            #1;
            chk("sweep_total", 32'(ch_total), (r == 2) ? 1 : 0);
            chk("sweep_false", 32'(ch_false), (r == 2) ? 1 : 0);
        end

        // Clear with simultaneous update; snapshot retained
        do_reset();
        rd_ch = 3'd0;
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0);
        chk("clr_total", 32'(branch_predict_total), 0);
        chk("clr_false", 32'(branch_false), 0);
        chk("clr_ch0", 32'(ch_total), 0);
        chk("clr_max", 32'(miss_run_max), 0);
        chk("clr_snap", 32'(snap_total), 8);

        // First window pulse after reset
        do_reset();
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (window_done) k = i;
        end
        chk("win_edge", k, 8);
        chk("win_snap", 32'(snap_total), 8);

        // Three freeze cycles delay the pulse by three
        do_reset();
        k = 0; edges = 0;
        for (int i = 0; i < 3; i++) begin cyc(1, 0, 0, 0, 0); edges++; end
        for (int i = 0; i < 3; i++) begin cyc(1, 0, 1, 0, 1); edges++; end
        for (int i = 0; i < 20 && k == 0; i++) begin
            cyc(1, 0, 0, 0, 0); edges++;
            if (window_done) k = edges;
        end
        chk("frz_edge", k, 11);
        chk("frz_snap", 32'(snap_total), 8);

        // Seventeen hazards: saturate or wrap
        do_reset();
        for (int i = 0; i < 17; i++) cyc(1, 0, 1, 0, 0);
`ifdef BRANCH_PERF_SATURATE_EN
        chk("sat_total", 32'(branch_predict_total), 15);
        chk("sat_false", 32'(branch_false), 15);
        chk("sat_max", 32'(miss_run_max), 15);
`else
        chk("wrap_total", 32'(branch_predict_total), 1);
        chk("wrap_false", 32'(branch_false), 1);
        chk("wrap_max", 32'(miss_run_max), 15);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rd_ch = CH_W'($urandom_range(0, 7));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
